// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Round-robin sharing of one combinational ALU between two
//             requesters, with a valid/ready result return channel.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,

  output logic              busy,
  output logic [CNT_W-1:0]  ops_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_grant_id;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [CTRL_W-1:0] r_op_ctrl;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_ops_count;

  logic              w_idle;
  logic              w_sel;
  logic              w_accept;
  logic              w_rsp_fire;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [CTRL_W-1:0] w_sel_ctrl;

  assign w_idle = (r_state == S_IDLE);

  // Under contention the requester that did not win last time gets the ALU.
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end
  end

  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_sel;
  assign req1_ready = w_idle && req1_valid &&  w_sel;

  assign w_sel_a    = w_sel ? req1_a    : req0_a;
  assign w_sel_b    = w_sel ? req1_b    : req0_b;
  assign w_sel_ctrl = w_sel ? req1_ctrl : req0_ctrl;

  assign rsp0_valid = (r_state == S_RESP) && !r_grant_id;
  assign rsp1_valid = (r_state == S_RESP) &&  r_grant_id;
  assign w_rsp_fire = (r_state == S_RESP) &&
                      (r_grant_id ? rsp1_ready : rsp0_ready);

  assign alu_a      = r_op_a;
  assign alu_b      = r_op_b;
  assign alu_ctrl   = r_op_ctrl;
  assign rsp_result = r_result;
  assign busy       = !w_idle;
  assign ops_count  = r_ops_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctrl    <= '0;
      r_result     <= '0;
      r_ops_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a     <= w_sel_a;
            r_op_b     <= w_sel_b;
            r_op_ctrl  <= w_sel_ctrl;
            r_grant_id <= w_sel;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= alu_result;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          // Result stays registered until the granted requester takes it.
          if (w_rsp_fire) begin
            r_last_grant <= r_grant_id;
            r_ops_count  <= r_ops_count + 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Directed, self-checking bench for alu_share_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 4;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              busy;
  logic [CNT_W-1:0]  ops_count;

  int         n_checks;
  int         n_errors;
  logic [3:0] exp_cnt;

  alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .busy       (busy),
    .ops_count  (ops_count)
  );

  // The external ALU the arbiter drives.
  always_comb begin
    alu_result = '0;
    if (alu_ctrl == OP_ADD)      alu_result = alu_a + alu_b;
    else if (alu_ctrl == OP_SUB) alu_result = alu_a - alu_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one uncontended op through accept, EXEC, RESP and the response handshake.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctrl, input logic [31:0] exp, input string tag);
    if (sel == 0) begin
      req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_valid = 1'b1;
    end
    #1;
    check({tag, "_rdy_win"},  32'(sel == 0 ? req0_ready : req1_ready), 32'd1);
    check({tag, "_rdy_lose"}, 32'(sel == 0 ? req1_ready : req0_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_rspv"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check({tag, "_alu_a"}, alu_a, a);
    check({tag, "_alu_b"}, alu_b, b);
    check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(ctrl));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rspv"}, 32'({rsp1_valid, rsp0_valid}), (sel == 0) ? 32'd1 : 32'd2);
    check({tag, "_result"}, rsp_result, exp);
    if (sel == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(ops_count), 32'(exp_cnt));
  endtask

  // Wait (bounded) for a response, check its owner/value and consume it.
  task automatic wait_rsp(input int exp_sel, input logic [31:0] exp, input string tag);
    int cyc;
    cyc = 0;
    while (!(rsp0_valid || rsp1_valid) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(rsp0_valid || rsp1_valid), 32'd1);
    check({tag, "_owner"}, 32'({rsp1_valid, rsp0_valid}), (exp_sel == 0) ? 32'd1 : 32'd2);
    check({tag, "_result"}, rsp_result, exp);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check({tag, "_count"}, 32'(ops_count), 32'(exp_cnt));
  endtask

  initial begin
    vecs[0] = '{0, 32'd5,          32'd3, OP_ADD,  32'd8};
    vecs[1] = '{0, 32'd7,          32'd9, 4'b1111, 32'd0};
    vecs[2] = '{1, 32'd100,        32'd1, OP_SUB,  32'd99};
    vecs[3] = '{0, 32'hFFFF_FFFF,  32'd2, OP_ADD,  32'd1};
    vecs[4] = '{1, 32'd0,          32'd1, OP_SUB,  32'hFFFF_FFFF};
    vecs[5] = '{1, 32'd12,         32'd4, 4'b0000, 32'd0};
    vecs[6] = '{1, 32'h1234_0000,  32'h5678, OP_ADD, 32'h1234_5678};

    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 4'd0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_rspv",   32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rst_rdy",    32'({req1_ready, req0_ready}), 32'd0);
    check("rst_count",  32'(ops_count), 32'd0);
    check("rst_alu_a",  alu_a, 32'd0);
    check("rst_alu_b",  alu_b, 32'd0);
    check("rst_alu_ct", 32'(alu_ctrl), 32'd0);
    check("rst_result", rsp_result, 32'd0);

    // Contention from reset: both requesters hold valid throughout.
    rst_n = 1'b1;
    req0_a = 32'd1;  req0_b = 32'd1; req0_ctrl = OP_ADD; req0_valid = 1'b1;
    req1_a = 32'd10; req1_b = 32'd4; req1_ctrl = OP_SUB; req1_valid = 1'b1;
    #1;
    check("tie_rdy0", 32'(req0_ready), 32'd1);
    check("tie_rdy1", 32'(req1_ready), 32'd0);
    wait_rsp(0, 32'd2, "rr0");
    wait_rsp(1, 32'd6, "rr1");
    wait_rsp(0, 32'd2, "rr2");
    wait_rsp(1, 32'd6, "rr3");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("rr_idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].exp,
             $sformatf("v%0d", i));
    end

    // Backpressure on requester 1 with requester 0 waiting.
    req1_a = 32'd3; req1_b = 32'd5; req1_ctrl = OP_SUB; req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_ctrl = OP_ADD; req0_valid = 1'b1;
    rsp0_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rspv", i),   32'({rsp1_valid, rsp0_valid}), 32'd2);
      check($sformatf("bp%0d_result", i), rsp_result, 32'hFFFF_FFFE);
      check($sformatf("bp%0d_busy", i),   32'(busy), 32'd1);
      check($sformatf("bp%0d_rdy0", i),   32'(req0_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check("bp_rel_busy",  32'(busy), 32'd0);
    check("bp_rel_count", 32'(ops_count), 32'(exp_cnt));
    check("bp_rel_rdy0",  32'(req0_ready), 32'd1);
    req0_valid = 1'b0;

    // Reset asserted while a response is pending.
    @(negedge clk);
    req0_a = 32'd20; req0_b = 32'd22; req0_ctrl = OP_ADD; req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rspv_pre", 32'(rsp0_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rspv",   32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("mid_busy",   32'(busy), 32'd0);
    check("mid_count",  32'(ops_count), 32'd0);
    check("mid_alu_a",  alu_a, 32'd0);
    check("mid_alu_ct", 32'(alu_ctrl), 32'd0);
    check("mid_result", rsp_result, 32'd0);
    exp_cnt = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    req1_a = 32'd50; req1_b = 32'd8; req1_ctrl = OP_SUB; req1_valid = 1'b1;
    req0_a = 32'd2;  req0_b = 32'd3; req0_ctrl = OP_ADD; req0_valid = 1'b1;
    #1;
    check("mid_tie_rdy0", 32'(req0_ready), 32'd1);
    check("mid_tie_rdy1", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;

    // Seventeen completions on a 4-bit counter, starting with the tie winner.
    for (int i = 0; i < 17; i++) begin
      run_op(i % 2, 32'(i + 2), 32'd3, OP_ADD, 32'(i + 5), $sformatf("w%0d", i));
    end
    check("wrap_count", 32'(ops_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
